mp_sub_sequencer: RTL and testbench

Multi-precision subtract sequencer for the ALU. It accepts a command giving an operand length of 1..MAX_WORDS words and then takes that many (A, B) word pairs, least-significant first. Each pair goes through a registered word-wide subtract stage, and the borrow is chained across words. Differences leave on a valid/ready stream, and the final word carries the result borrow.

---
 rtl/mp_sub_pkg.sv | 26 ++
 rtl/mp_sub_sequencer_stage.sv | 54 +++++
 rtl/mp_sub_sequencer.sv | 108 ++++++++++
 tb/tb_mp_sub_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_sub_pkg.sv
// ============================================================================
// Module : mp_sub_pkg
// Brief  : Shared types and sizing for the multi-precision subtract sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mp_sub_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int MAX_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Count fields must hold MAX_WORDS itself, not just MAX_WORDS-1.
  function automatic int cnt_width(input int max_words);
    return $clog2(max_words) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_sub_sequencer_stage.sv
// ============================================================================
// Module : sub_word_stage
// Brief  : Registered word subtract with borrow, plus output hold/load logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sub_word_stage
  import mp_sub_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              borrow_in,
  input  logic              last_in,
  input  logic              out_ready,
  output logic              borrow_out,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_diff,
  output logic              out_last,
  output logic              out_borrow
);

  // One extra bit exposes the borrow as the sign of the wide difference.
  logic [WORD_W:0] wide_diff;

  assign wide_diff  = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, borrow_in};
  assign borrow_out = wide_diff[WORD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_last   <= 1'b0;
      out_borrow <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_diff   <= wide_diff[WORD_W-1:0];
      out_last   <= last_in;
      out_borrow <= last_in & borrow_out;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_borrow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mp_sub_sequencer.sv
// ============================================================================
// Module : mp_sub_sequencer
// Brief  : Multi-word subtract sequencer: command, operand stream, diff stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mp_sub_sequencer
  import mp_sub_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CNT_W     = cnt_width(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_nwords,
  input  logic              cmd_borrow_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_diff,
  output logic              out_last,
  output logic              out_borrow,
  output logic              busy,
  output logic              err
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   idx;
  logic               chain;
  logic               chain_next;
  logic               cmd_legal;
  logic               cmd_take;
  logic               word_take;
  logic               word_last;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign cmd_legal = (cmd_nwords != '0) && (cmd_nwords <= CNT_W'(MAX_WORDS));
  assign cmd_take  = cmd_ready && cmd_valid;
  // Stall input in the same cycle the output register cannot drain.
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign word_take = in_valid && in_ready;
  assign word_last = (idx == count - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_take && cmd_legal) state_next = S_RUN;
      S_RUN:   if (word_take && word_last) state_next = S_FLUSH;
      S_FLUSH: if (out_valid && out_ready && out_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      idx   <= '0;
      chain <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= cmd_take && !cmd_legal;
      if (cmd_take && cmd_legal) begin
        count <= cmd_nwords;
        idx   <= '0;
        chain <= cmd_borrow_in;
      end else if (word_take) begin
        idx   <= idx + CNT_W'(1);
        chain <= chain_next;
      end
    end
  end

  sub_word_stage #(
    .WORD_W (WORD_W)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .load       (word_take),
    .a          (in_a),
    .b          (in_b),
    .borrow_in  (chain),
    .last_in    (word_last),
    .out_ready  (out_ready),
    .borrow_out (chain_next),
    .out_valid  (out_valid),
    .out_diff   (out_diff),
    .out_last   (out_last),
    .out_borrow (out_borrow)
  );

endmodule

`default_nettype wire

// File: tb/tb_mp_sub_sequencer.sv
// ============================================================================
// Module : tb_mp_sub_sequencer
// Brief  : Directed and randomized checks of mp_sub_sequencer against a wide
//          integer subtraction model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mp_sub_sequencer;

  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 8;
  localparam int CNT_W     = 4;
  localparam int BIG_W     = WORD_W * MAX_WORDS + 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_nwords = '0;
  logic              cmd_borrow_in = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_a = '0;
  logic [WORD_W-1:0] in_b = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WORD_W-1:0] out_diff;
  logic              out_last;
  logic              out_borrow;
  logic              busy;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [WORD_W-1:0] wa [MAX_WORDS];
  logic [WORD_W-1:0] wb [MAX_WORDS];

  always #5 clk = ~clk;

  mp_sub_sequencer #(
    .WORD_W    (WORD_W),
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_nwords    (cmd_nwords),
    .cmd_borrow_in (cmd_borrow_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_diff      (out_diff),
    .out_last      (out_last),
    .out_borrow    (out_borrow),
    .busy          (busy),
    .err           (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input int n, input bit bin);
    @(negedge clk);
    check("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid     = 1'b1;
    cmd_nwords    = CNT_W'(n);
    cmd_borrow_in = bin;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Runs one full command over wa/wb; the expected result is the plain
  // wide-integer difference A - B - bin sliced back into words.
  task automatic run_cmd(input int n, input bit bin, input int stall_start,
                         input int stall_len, output int cycles);
    logic [BIG_W-1:0]  big_a, big_b, big_d;
    logic              exp_borrow;
    logic [WORD_W-1:0] held_diff;
    logic              held_last;
    bit                held;
    bit                take;
    int                sent, got;
    big_a = '0;
    big_b = '0;
    for (int i = 0; i < n; i++) begin
      big_a[WORD_W*i +: WORD_W] = wa[i];
      big_b[WORD_W*i +: WORD_W] = wb[i];
    end
    big_d      = big_a - big_b - BIG_W'(bin);
    exp_borrow = (big_a < big_b + BIG_W'(bin));

    issue_cmd(n, bin);
    sent   = 0;
    got    = 0;
    cycles = 0;
    held   = 0;
    held_diff = '0;
    held_last = 1'b0;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      out_ready = !(cycles >= stall_start && cycles < stall_start + stall_len);
      in_valid  = (sent < n);
      if (sent < n) begin
        in_a = wa[sent];
        in_b = wb[sent];
      end
      #1;
      if (out_valid && out_ready) begin
        check("out_diff", 64'(out_diff), 64'(big_d[WORD_W*got +: WORD_W]));
        check("out_last", 64'(out_last), 64'(got == n - 1));
        check("out_borrow", 64'(out_borrow), 64'((got == n - 1) ? exp_borrow : 1'b0));
        got++;
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        if (held) begin
          check("stall_diff_hold", 64'(out_diff), 64'(held_diff));
          check("stall_last_hold", 64'(out_last), 64'(held_last));
        end
        held      = 1;
        held_diff = out_diff;
        held_last = out_last;
      end else begin
        held = 0;
      end
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) sent++;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("words_received", 64'(got), 64'(n));
    check("words_sent", 64'(sent), 64'(n));
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic illegal_cmd(input int n);
    issue_cmd(n, 1'b0);
    @(negedge clk);
    check("err_pulse", 64'(err), 64'd1);
    check("err_no_busy", 64'(busy), 64'd0);
    check("err_cmd_ready", 64'(cmd_ready), 64'd1);
    check("err_no_out", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("err_one_cycle", 64'(err), 64'd0);
    check("err_no_out_later", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_diff", 64'(out_diff), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_borrow", 64'(out_borrow), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    // Single word 5 - 3
    wa[0] = 32'd5; wb[0] = 32'd3;
    run_cmd(1, 1'b0, 99, 0, cyc);

    // Two words with borrow chained across
    wa[0] = 32'd0; wb[0] = 32'd1;
    wa[1] = 32'd1; wb[1] = 32'd0;
    run_cmd(2, 1'b0, 99, 0, cyc);

    // Borrow out from operands, then from borrow_in alone
    wa[0] = 32'd0; wb[0] = 32'd1;
    run_cmd(1, 1'b0, 99, 0, cyc);
    wa[0] = 32'd0; wb[0] = 32'd0;
    run_cmd(1, 1'b1, 99, 0, cyc);

    // Eight words back to back: RUN through last output in 9 cycles
    for (int i = 0; i < MAX_WORDS; i++) begin
      wa[i] = $urandom; wb[i] = $urandom;
    end
    run_cmd(8, 1'b0, 99, 0, cyc);
    check("full_rate_cycles", 64'(cyc), 64'd9);

    // Eight words with a 3-cycle stall mid-stream
    for (int i = 0; i < MAX_WORDS; i++) begin
      wa[i] = $urandom; wb[i] = $urandom;
    end
    run_cmd(8, 1'b1, 3, 3, cyc);
    check("stall_cycles", 64'(cyc), 64'd12);

    // Illegal lengths
    illegal_cmd(0);
    illegal_cmd(9);

    // Reset in the middle of a borrowing 4-word subtraction
    for (int i = 0; i < 4; i++) begin
      wa[i] = 32'd0; wb[i] = 32'd1;
    end
    issue_cmd(4, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = wa[i]; in_b = wb[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_diff", 64'(out_diff), 64'd0);
    check("mid_rst_out_last", 64'(out_last), 64'd0);
    check("mid_rst_out_borrow", 64'(out_borrow), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    wa[0] = 32'd7; wb[0] = 32'd2;
    run_cmd(1, 1'b0, 99, 0, cyc);

    // Randomized commands with random stalls
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, MAX_WORDS);
      for (int i = 0; i < MAX_WORDS; i++) begin
        wa[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
        wb[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      end
      run_cmd(n, 1'($urandom_range(0, 1)), $urandom_range(0, n),
              $urandom_range(0, 3), cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
